// File: rtl/bfly_pkg.sv
// ============================================================================
// Module  : bfly_pkg
// Brief   : Shared types and fixed-point helpers for the radix-2 butterfly.
//           BFLY_ROUND_EN selects round-half-up shifts instead of floor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bfly_pkg;

    localparam int H  = 16;
    // Intermediate width for shifts/saturation; covers 2H+1-bit products for H up to 31.
    localparam int XW = 64;

    typedef logic signed [XW-1:0] wide_t;

    typedef struct packed {
        logic signed [H-1:0] re;
        logic signed [H-1:0] im;
    } cplx_t;

    function automatic wide_t rnd_shr(input wide_t x, input int n);
`ifdef BFLY_ROUND_EN
        return (x + (wide_t'(1) <<< (n - 1))) >>> n;
`else
        return x >>> n;
`endif
    endfunction

    function automatic wide_t sat_h(input wide_t x, input int h, output logic ovf);
        wide_t hi;
        wide_t lo;
        wide_t res;
        hi  = (wide_t'(1) <<< (h - 1)) - wide_t'(1);
        lo  = -(wide_t'(1) <<< (h - 1));
        ovf = 1'b0;
        res = x;
        if (x > hi) begin
            res = hi;
            ovf = 1'b1;
        end else if (x < lo) begin
            res = lo;
            ovf = 1'b1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bfly_pipe_if.sv
// ============================================================================
// Module  : bfly_pipe_if
// Brief   : Operand/result handshake bundle of the butterfly pipeline.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface bfly_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] w;
    logic             scale;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf;
    logic             ovf_clr;

    modport master (
        output in_valid, a, b, w, scale, out_ready, ovf_clr,
        input  in_ready, out_valid, sum, diff, ovf
    );

    modport slave (
        input  in_valid, a, b, w, scale, out_ready, ovf_clr,
        output in_ready, out_valid, sum, diff, ovf
    );
endinterface

`default_nettype wire

// File: rtl/bfly_pipe_cmul.sv
// ============================================================================
// Module  : cmul_pipe
// Brief   : Registered complex multiply T = W*B with round/shift/saturate.
//           Rounding follows BFLY_ROUND_EN via bfly_pkg::rnd_shr.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cmul_pipe
    import bfly_pkg::*;
#(
    parameter int H    = 16,
    parameter int FRAC = H - 1
) (
    input  logic                clk,
    input  logic                en_i,
    input  logic signed [H-1:0] b_re_i,
    input  logic signed [H-1:0] b_im_i,
    input  logic signed [H-1:0] w_re_i,
    input  logic signed [H-1:0] w_im_i,
    output logic signed [H-1:0] t_re_o,
    output logic signed [H-1:0] t_im_o,
    output logic                t_ovf_o
);

    logic signed [2*H-1:0] p1_q, p2_q, p3_q, p4_q;
    logic signed [2*H:0]   w_tr, w_ti;
    logic                  w_ovf_re, w_ovf_im;

    always_ff @(posedge clk) begin
        if (en_i) begin
            p1_q <= (2*H)'(w_re_i) * (2*H)'(b_re_i);
            p2_q <= (2*H)'(w_im_i) * (2*H)'(b_im_i);
            p3_q <= (2*H)'(w_im_i) * (2*H)'(b_re_i);
            p4_q <= (2*H)'(w_re_i) * (2*H)'(b_im_i);
        end
    end

    assign w_tr = (2*H+1)'(p1_q) - (2*H+1)'(p2_q);
    assign w_ti = (2*H+1)'(p3_q) + (2*H+1)'(p4_q);

    always_comb begin
        w_ovf_re = 1'b0;
        w_ovf_im = 1'b0;
        t_re_o   = H'(sat_h(rnd_shr(wide_t'(w_tr), FRAC), H, w_ovf_re));
        t_im_o   = H'(sat_h(rnd_shr(wide_t'(w_ti), FRAC), H, w_ovf_im));
        t_ovf_o  = w_ovf_re | w_ovf_im;
    end

endmodule

`default_nettype wire

// File: rtl/bfly_pipe.sv
// ============================================================================
// Module  : bfly_pipe
// Brief   : 3-stage elastic radix-2 DIT butterfly: sum/diff = A +/- W*B with
//           scaling, saturation and sticky overflow. Macro: BFLY_ROUND_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bfly_pipe
    import bfly_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = WIDTH / 2 - 1
) (
    input  logic       clk,
    input  logic       rst_n,
    bfly_pipe_if.slave bus
);

    localparam int HW = WIDTH / 2;

    logic             v1_q, v2_q, v3_q;
    logic [WIDTH-1:0] a1_q, b1_q, w1_q, a2_q;
    logic             s1_q, s2_q;
    logic [WIDTH-1:0] sum_q, diff_q, sum_d, diff_d;
    logic             ovf_q, ovf_d;

    logic             w_adv1, w_adv2, w_adv3, w_ld2, w_ld3;
    logic signed [HW-1:0] w_a_re, w_a_im, w_t_re, w_t_im;
    logic             w_t_ovf;
    logic             w_ov_sr, w_ov_si, w_ov_dr, w_ov_di;

    // A stage may load when empty or when its successor is loading.
    assign w_adv3 = !v3_q || bus.out_ready;
    assign w_adv2 = !v2_q || w_adv3;
    assign w_adv1 = !v1_q || w_adv2;
    assign w_ld2  = w_adv2 && v1_q;
    assign w_ld3  = w_adv3 && v2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            sum_q  <= '0;
            diff_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (w_adv1) v1_q <= bus.in_valid;
            if (w_adv2) v2_q <= v1_q;
            if (w_adv3) v3_q <= v2_q;
            if (w_ld3) begin
                sum_q  <= sum_d;
                diff_q <= diff_d;
            end
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv1 && bus.in_valid) begin
            a1_q <= bus.a;
            b1_q <= bus.b;
            w1_q <= bus.w;
            s1_q <= bus.scale;
        end
        if (w_ld2) begin
            a2_q <= a1_q;
            s2_q <= s1_q;
        end
    end

    cmul_pipe #(
        .H    (HW),
        .FRAC (FRAC)
    ) u_cmul (
        .clk     (clk),
        .en_i    (w_ld2),
        .b_re_i  (b1_q[WIDTH-1:HW]),
        .b_im_i  (b1_q[HW-1:0]),
        .w_re_i  (w1_q[WIDTH-1:HW]),
        .w_im_i  (w1_q[HW-1:0]),
        .t_re_o  (w_t_re),
        .t_im_o  (w_t_im),
        .t_ovf_o (w_t_ovf)
    );

    assign w_a_re = a2_q[WIDTH-1:HW];
    assign w_a_im = a2_q[HW-1:0];

    function automatic wide_t lane_sat(input wide_t x, input logic sc, output logic ov);
        return sat_h(sc ? rnd_shr(x, 1) : x, HW, ov);
    endfunction

    always_comb begin
        w_ov_sr = 1'b0;
        w_ov_si = 1'b0;
        w_ov_dr = 1'b0;
        w_ov_di = 1'b0;
        sum_d   = '0;
        diff_d  = '0;
        sum_d[WIDTH-1:HW]  = HW'(lane_sat(wide_t'(w_a_re) + wide_t'(w_t_re), s2_q, w_ov_sr));
        sum_d[HW-1:0]      = HW'(lane_sat(wide_t'(w_a_im) + wide_t'(w_t_im), s2_q, w_ov_si));
        diff_d[WIDTH-1:HW] = HW'(lane_sat(wide_t'(w_a_re) - wide_t'(w_t_re), s2_q, w_ov_dr));
        diff_d[HW-1:0]     = HW'(lane_sat(wide_t'(w_a_im) - wide_t'(w_t_im), s2_q, w_ov_di));
        // A fresh saturation outranks a same-cycle clear.
        ovf_d = ovf_q;
        if (bus.ovf_clr) ovf_d = 1'b0;
        if (w_ld3 && (w_t_ovf || w_ov_sr || w_ov_si || w_ov_dr || w_ov_di)) ovf_d = 1'b1;
    end

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = v3_q;
    assign bus.sum       = sum_q;
    assign bus.diff      = diff_q;
    assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bfly_pipe.sv
// ============================================================================
// Module  : tb_bfly_pipe
// Brief   : Directed and randomised checks of bfly_pipe (WIDTH=32, FRAC=15).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bfly_pipe;

`ifdef BFLY_ROUND_EN
    localparam logic [31:0] V1_SUM = 32'h3000_0000;
    localparam logic [31:0] V1_DIF = 32'hF000_0000;
    localparam logic [31:0] V3_SUM = 32'h7000_0000;
    localparam logic [31:0] V3_DIF = 32'h0001_0000;
`else
    localparam logic [31:0] V1_SUM = 32'h2FFF_0000;
    localparam logic [31:0] V1_DIF = 32'hF001_0000;
    localparam logic [31:0] V3_SUM = 32'h6FFF_0000;
    localparam logic [31:0] V3_DIF = 32'h0000_0000;
`endif
    localparam int NRAND = 10000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [63:0] exp_q[$];

    bfly_pipe_if #(.WIDTH(32)) bus ();

    bfly_pipe #(.WIDTH(32), .FRAC(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic on plain integers.
    function automatic longint s16(input logic [15:0] v);
        return longint'(signed'(v));
    endfunction

    function automatic longint shr_m(input longint x, input int n);
`ifdef BFLY_ROUND_EN
        return (x + (longint'(1) << (n - 1))) >>> n;
`else
        return x >>> n;
`endif
    endfunction

    function automatic logic [16:0] clamp_m(input longint x);
        if (x > 32767)  return {1'b1, 16'h7FFF};
        if (x < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(x)};
    endfunction

    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] w, input logic sc);
        longint      tr, ti;
        longint      l[4];
        logic [16:0] r;
        logic [15:0] trs, tis;
        logic [15:0] o[4];
        logic        ov;
        tr  = s16(w[31:16]) * s16(b[31:16]) - s16(w[15:0]) * s16(b[15:0]);
        ti  = s16(w[15:0]) * s16(b[31:16]) + s16(w[31:16]) * s16(b[15:0]);
        ov  = 1'b0;
        r   = clamp_m(shr_m(tr, 15));
        ov  = ov | r[16];
        trs = r[15:0];
        r   = clamp_m(shr_m(ti, 15));
        ov  = ov | r[16];
        tis = r[15:0];
        l[0] = s16(a[31:16]) + s16(trs);
        l[1] = s16(a[15:0])  + s16(tis);
        l[2] = s16(a[31:16]) - s16(trs);
        l[3] = s16(a[15:0])  - s16(tis);
        for (int k = 0; k < 4; k++) begin
            if (sc) l[k] = shr_m(l[k], 1);
            r    = clamp_m(l[k]);
            ov   = ov | r[16];
            o[k] = r[15:0];
        end
        return {ov, o[0], o[1], o[2], o[3]};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic send_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                            input logic [31:0] tw, input logic tsc,
                            input logic [31:0] esum, input logic [31:0] edif);
        int lat;
        bus.a = ta; bus.b = tb; bus.w = tw; bus.scale = tsc;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #3;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
        check({tag, "_sum_diff"}, {bus.sum, bus.diff}, {esum, edif});
        step();
    endtask

    logic [31:0] bp_a[5], bp_b[5], bp_w[5];
    logic [63:0] bp_e[5];
    logic [64:0] m;
    int          idx, nout, gaps, seen, sent, got, cyc;

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.w = '0; bus.scale = 1'b0;
        bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
        step();
        step();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum_diff", {bus.sum, bus.diff}, 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        send_one("v1", 32'h1000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0, V1_SUM, V1_DIF);
        check("v1_ovf", 64'(bus.ovf), 64'd0);

        send_one("v2", 32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 32'h7FFF_0000, 32'h0001_0000);
        check("v2_ovf", 64'(bus.ovf), 64'd1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", 64'(bus.ovf), 64'd0);

        send_one("v3", 32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b1, V3_SUM, V3_DIF);
        check("v3_ovf", 64'(bus.ovf), 64'd0);

        send_one("corner", 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h7FFF_0000, 32'h8001_0000);
        check("corner_ovf", 64'(bus.ovf), 64'd1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;

        // Backpressure: five vectors against a stalled sink.
        for (int k = 0; k < 5; k++) begin
            bp_a[k] = 32'h0100_0200 + 32'(k) * 32'h0011_0013;
            bp_b[k] = 32'h0400_FC00 - 32'(k) * 32'h0101_0070;
            bp_w[k] = (k % 2 == 0) ? 32'h5A82_A57E : 32'h7FFF_0000;
            m       = model(bp_a[k], bp_b[k], bp_w[k], 1'(k % 2));
            bp_e[k] = m[63:0];
        end
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = 1'b1;
            bus.a = bp_a[idx]; bus.b = bp_b[idx]; bus.w = bp_w[idx]; bus.scale = 1'(idx % 2);
            #3;
            if (bus.in_ready) idx++;
            step();
        end
        check("bp_accepted", 64'(idx), 64'd3);
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        for (int c = 0; c < 10; c++) begin
            check("bp_hold", {bus.sum, bus.diff}, bp_e[0]);
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            step();
        end
        bus.out_ready = 1'b1;
        nout = 0;
        gaps = 0;
        for (int c = 0; c < 20 && nout < 5; c++) begin
            bus.in_valid = (idx < 5);
            if (idx < 5) begin
                bus.a = bp_a[idx]; bus.b = bp_b[idx]; bus.w = bp_w[idx]; bus.scale = 1'(idx % 2);
            end
            #3;
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid) begin
                check("bp_order", {bus.sum, bus.diff}, bp_e[nout]);
                nout++;
            end else if (nout > 0) begin
                gaps++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("bp_count", 64'(nout), 64'd5);
        check("bp_gaps", 64'(gaps), 64'd0);

        // Reset with three items in flight.
        bus.out_ready = 1'b0;
        bus.a = 32'h7000_0000; bus.b = 32'h7000_0000; bus.w = 32'h7FFF_0000; bus.scale = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        check("mid_pre_ovf", 64'(bus.ovf), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_sum_diff", {bus.sum, bus.diff}, 64'd0);
        check("mid_ovf", 64'(bus.ovf), 64'd0);
        check("mid_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            #3;
            if (bus.out_valid) seen++;
            step();
        end
        check("mid_no_stale", 64'(seen), 64'd0);

        // Random traffic against the reference model.
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < NRAND && cyc < 80000) begin
            bus.in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.a = {rnd16(), rnd16()};
            bus.b = {rnd16(), rnd16()};
            bus.w = {rnd16(), rnd16()};
            bus.scale = 1'($urandom_range(0, 1));
            #3;
            if (bus.in_valid && bus.in_ready) begin
                m = model(bus.a, bus.b, bus.w, bus.scale);
                exp_q.push_back(m[63:0]);
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_output", 64'(bus.out_valid), 64'd0);
                end else begin
                    check("rnd_data", {bus.sum, bus.diff}, exp_q.pop_front());
                end
                got++;
            end
            cyc++;
            step();
        end
        bus.in_valid = 1'b0;
        check("rnd_all_received", 64'(got), 64'(NRAND));
        check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
